// File: rtl/timer_arb_pkg.sv
// Shared state encoding and sizing helpers for the countdown timer arbiter.
package timer_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    localparam int N_REQ_DEFAULT = 4;
    localparam int WIDTH_DEFAULT = 16;
    localparam int IDX_W         = $clog2(N_REQ_DEFAULT);

    // Index width for an arbitrary requester count; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_arbiter
    import timer_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT,
    parameter int PTR_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic             valid
);

    // Offset i is tried in priority order; position j is matched by constant index.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (!valid && req[j] && (j == (int'(ptr) + i) % N_REQ)) begin
                    grant[j] = 1'b1;
                    valid    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/up_down_counter.sv
// Loadable up/down counter with one-cycle overflow/underflow flags and selectable reset style.
module up_down_counter #(
    parameter int WIDTH      = 16,
    parameter bit SYNC_RESET = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] count,
    output logic             ovf,
    output logic             udf
);

    logic [WIDTH-1:0] count_next;
    logic             ovf_next;
    logic             udf_next;

    // Load has priority over counting; the flags mark a wrap on this step.
    always_comb begin
        count_next = count;
        ovf_next   = 1'b0;
        udf_next   = 1'b0;
        if (load) begin
            count_next = load_data;
        end else if (en) begin
            if (up_down) begin
                count_next = count + WIDTH'(1);
                ovf_next   = &count;
            end else begin
                count_next = count - WIDTH'(1);
                udf_next   = ~|count;
            end
        end
    end

    if (SYNC_RESET) begin : g_sync_rst
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                count <= '0;
                ovf   <= 1'b0;
                udf   <= 1'b0;
            end else begin
                count <= count_next;
                ovf   <= ovf_next;
                udf   <= udf_next;
            end
        end
    end else begin : g_async_rst
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                count <= '0;
                ovf   <= 1'b0;
                udf   <= 1'b0;
            end else begin
                count <= count_next;
                ovf   <= ovf_next;
                udf   <= udf_next;
            end
        end
    end

endmodule

// File: rtl/countdown_timer_arbiter.sv
// One shared down-counting timer, handed round-robin to N_REQ requesters.
module countdown_timer_arbiter
    import timer_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT,
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [N_REQ-1:0]       i_req,
    input  logic [N_REQ*WIDTH-1:0] i_load_val,
    output logic [N_REQ-1:0]       o_grant,
    output logic [N_REQ-1:0]       o_done,
    output logic                   o_busy,
    output logic [WIDTH-1:0]       o_count
);

    localparam int               PTR_W = idx_width(N_REQ);
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(N_REQ - 1);

    state_t           state;
    logic [PTR_W-1:0] owner;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] next_ptr;
    logic [PTR_W-1:0] arb_idx;
    logic [N_REQ-1:0] arb_grant;
    logic             arb_valid;
    logic             owner_req;
    logic [WIDTH-1:0] load_data;
    logic             cnt_en;
    logic             cnt_load;
    logic             ovf_unused;
    logic             udf_unused;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req   (i_req),
        .ptr   (ptr),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    always_comb begin
        arb_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_grant[i]) arb_idx = PTR_W'(i);
        end
    end

    // Owner's request line and delay value, selected by the registered owner index.
    always_comb begin
        owner_req = 1'b0;
        load_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner == PTR_W'(i)) begin
                owner_req = i_req[i];
                load_data = i_load_val[i*WIDTH +: WIDTH];
            end
        end
    end

    assign next_ptr = (owner == LAST) ? '0 : owner + PTR_W'(1);
    assign cnt_en   = (state == RUN) && (o_count != '0);
    assign cnt_load = (state == LOAD);
    assign o_busy   = (state != IDLE);

    up_down_counter #(
        .WIDTH      (WIDTH),
        .SYNC_RESET (1'b0)
    ) u_cnt (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .en        (cnt_en),
        .up_down   (1'b0),
        .load      (cnt_load),
        .load_data (load_data),
        .count     (o_count),
        .ovf       (ovf_unused),
        .udf       (udf_unused)
    );

    // Every path back to IDLE clears the grant, so IDLE always shows o_grant == 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            owner   <= '0;
            ptr     <= '0;
            o_grant <= '0;
            o_done  <= '0;
        end else begin
            o_done <= '0;
            unique case (state)
                IDLE: begin
                    if (arb_valid) begin
                        owner   <= arb_idx;
                        o_grant <= arb_grant;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    if (!owner_req) begin
                        state   <= IDLE;
                        o_grant <= '0;
                        ptr     <= next_ptr;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!owner_req) begin
                        state   <= IDLE;
                        o_grant <= '0;
                        ptr     <= next_ptr;
                    end else if (o_count == '0) begin
                        state  <= DONE;
                        o_done <= o_grant;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    o_grant <= '0;
                    ptr     <= next_ptr;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_countdown_timer_arbiter.sv
// Scenario bench for countdown_timer_arbiter: per-cycle grant/count checks plus a done-pulse scoreboard.
module tb_countdown_timer_arbiter;

    localparam int N = 4;
    localparam int W = 16;

    logic           i_clk = 1'b0;
    logic           i_rst_n;
    logic [N-1:0]   i_req;
    logic [N*W-1:0] i_load_val;
    logic [N-1:0]   o_grant;
    logic [N-1:0]   o_done;
    logic           o_busy;
    logic [W-1:0]   o_count;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [N-1:0] exp_q[$];
    int           exp_cyc_q[$];

    countdown_timer_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_req      (i_req),
        .i_load_val (i_load_val),
        .o_grant    (o_grant),
        .o_done     (o_done),
        .o_busy     (o_busy),
        .o_count    (o_count)
    );

    // Clock and cycle counter
    initial forever #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Inputs change on negedges; release of reset also lands on a negedge.
    task automatic do_reset();
        @(negedge i_clk);
        i_rst_n    = 1'b0;
        i_req      = '0;
        i_load_val = '0;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        exp_q.delete();
        exp_cyc_q.delete();
    endtask

    task automatic test_reset();
        i_rst_n    = 1'b0;
        i_req      = '0;
        i_load_val = '0;
        repeat (2) @(negedge i_clk);
        n_vec++; if (o_grant !== 4'b0000) begin n_err++; $display("FAIL reset_grant: got %b, expected 0000", o_grant); end
        n_vec++; if (o_done !== 4'b0000) begin n_err++; $display("FAIL reset_done: got %b, expected 0000", o_done); end
        n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b, expected 0", o_busy); end
        n_vec++; if (o_count !== 16'h0000) begin n_err++; $display("FAIL reset_count: got %h, expected 0000", o_count); end
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);
        n_vec++; if (o_busy !== 1'b0 || o_grant !== 4'b0000) begin
            n_err++; $display("FAIL idle_after_reset: busy=%b grant=%b, expected 0 / 0000", o_busy, o_grant);
        end
    endtask

    task automatic test_single();
        int t0, k, e_cyc;
        logic [N-1:0] eg, e_done;
        logic [W-1:0] ec;
        do_reset();
        t0 = cyc;
        i_load_val[15:0] = 16'd5;
        i_req = 4'b0001;
        exp_q.push_back(4'b0001); exp_cyc_q.push_back(t0 + 8);
        for (int n = 0; n < 12; n++) begin
            @(negedge i_clk);
            k  = cyc - t0;
            eg = (k >= 1 && k <= 8) ? 4'b0001 : 4'b0000;
            n_vec++; if (o_grant !== eg) begin n_err++; $display("FAIL single_grant: cycle %0d got %b, expected %b", k, o_grant, eg); end
            n_vec++; if (o_busy !== |eg) begin n_err++; $display("FAIL single_busy: cycle %0d got %b, expected %b", k, o_busy, |eg); end
            if (k >= 2) begin
                ec = (k <= 7) ? W'(7 - k) : 16'd0;
                n_vec++; if (o_count !== ec) begin n_err++; $display("FAIL single_count: cycle %0d got %h, expected %h", k, o_count, ec); end
            end
            if (o_done !== '0 || (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc)) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL single_done: cycle %0d got %b, expected no pulse", k, o_done);
                end else begin
                    e_done = exp_q.pop_front(); e_cyc = exp_cyc_q.pop_front();
                    if (o_done !== e_done || cyc != e_cyc) begin
                        n_err++; $display("FAIL single_done: got %b at cycle %0d, expected %b at cycle %0d", o_done, k, e_done, e_cyc - t0);
                    end
                end
            end
            if (k == 8) i_req = 4'b0000;
        end
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL single_missing: %0d pulses pending, expected 0", exp_q.size()); end
    endtask

    task automatic test_all_req();
        int t0, k, slot, ph, e_cyc;
        logic [N-1:0] eg, e_done;
        logic [W-1:0] ec;
        do_reset();
        t0 = cyc;
        i_load_val = {4{16'd2}};
        i_req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            exp_q.push_back(4'(1 << (j % 4)));
            exp_cyc_q.push_back(t0 + 5 + 6 * j);
        end
        for (int n = 0; n < 33; n++) begin
            @(negedge i_clk);
            k    = cyc - t0;
            slot = (k - 1) / 6;
            ph   = (k - 1) % 6;
            eg   = (slot < 5 && ph <= 4) ? 4'(1 << (slot % 4)) : 4'b0000;
            n_vec++; if (o_grant !== eg) begin n_err++; $display("FAIL rr_grant: cycle %0d got %b, expected %b", k, o_grant, eg); end
            n_vec++; if (o_busy !== |eg) begin n_err++; $display("FAIL rr_busy: cycle %0d got %b, expected %b", k, o_busy, |eg); end
            if (slot < 5 && ph >= 1 && ph <= 3) begin
                ec = W'(3 - ph);
                n_vec++; if (o_count !== ec) begin n_err++; $display("FAIL rr_count: cycle %0d got %h, expected %h", k, o_count, ec); end
            end
            if (o_done !== '0 || (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc)) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL rr_done: cycle %0d got %b, expected no pulse", k, o_done);
                end else begin
                    e_done = exp_q.pop_front(); e_cyc = exp_cyc_q.pop_front();
                    if (o_done !== e_done || cyc != e_cyc) begin
                        n_err++; $display("FAIL rr_done: got %b at cycle %0d, expected %b at cycle %0d", o_done, k, e_done, e_cyc - t0);
                    end
                end
            end
            if (k == 29) i_req = 4'b0000;
        end
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rr_missing: %0d pulses pending, expected 0", exp_q.size()); end
    endtask

    task automatic test_zero_delay();
        int t0, k, e_cyc;
        logic [N-1:0] eg, e_done;
        do_reset();
        t0 = cyc;
        i_load_val[47:32] = 16'd0;
        i_req = 4'b0100;
        exp_q.push_back(4'b0100); exp_cyc_q.push_back(t0 + 3);
        for (int n = 0; n < 8; n++) begin
            @(negedge i_clk);
            k  = cyc - t0;
            eg = (k >= 1 && k <= 3) ? 4'b0100 : 4'b0000;
            n_vec++; if (o_grant !== eg) begin n_err++; $display("FAIL zero_grant: cycle %0d got %b, expected %b", k, o_grant, eg); end
            if (k >= 2) begin
                n_vec++; if (o_count !== 16'h0000) begin n_err++; $display("FAIL zero_count: cycle %0d got %h, expected 0000", k, o_count); end
            end
            if (o_done !== '0 || (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc)) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL zero_done: cycle %0d got %b, expected no pulse", k, o_done);
                end else begin
                    e_done = exp_q.pop_front(); e_cyc = exp_cyc_q.pop_front();
                    if (o_done !== e_done || cyc != e_cyc) begin
                        n_err++; $display("FAIL zero_done: got %b at cycle %0d, expected %b at cycle %0d", o_done, k, e_done, e_cyc - t0);
                    end
                end
            end
            if (k == 3) i_req = 4'b0000;
        end
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL zero_missing: %0d pulses pending, expected 0", exp_q.size()); end
    endtask

    task automatic test_abort();
        int t0, k, e_cyc;
        logic [N-1:0] eg, e_done;
        logic [W-1:0] ec;
        do_reset();
        t0 = cyc;
        i_load_val[15:0]  = 16'd10;
        i_load_val[31:16] = 16'd3;
        i_req = 4'b0011;
        exp_q.push_back(4'b0010); exp_cyc_q.push_back(t0 + 13);
        for (int n = 0; n < 16; n++) begin
            @(negedge i_clk);
            k  = cyc - t0;
            eg = (k >= 1 && k <= 6) ? 4'b0001 : (k >= 8 && k <= 13) ? 4'b0010 : 4'b0000;
            n_vec++; if (o_grant !== eg) begin n_err++; $display("FAIL abort_grant: cycle %0d got %b, expected %b", k, o_grant, eg); end
            n_vec++; if (o_busy !== |eg) begin n_err++; $display("FAIL abort_busy: cycle %0d got %b, expected %b", k, o_busy, |eg); end
            if ((k >= 2 && k <= 6) || (k >= 9 && k <= 13)) begin
                ec = (k == 13) ? 16'd0 : W'(12 - k);
                n_vec++; if (o_count !== ec) begin n_err++; $display("FAIL abort_count: cycle %0d got %h, expected %h", k, o_count, ec); end
            end
            if (o_done !== '0 || (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc)) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL abort_done: cycle %0d got %b, expected no pulse", k, o_done);
                end else begin
                    e_done = exp_q.pop_front(); e_cyc = exp_cyc_q.pop_front();
                    if (o_done !== e_done || cyc != e_cyc) begin
                        n_err++; $display("FAIL abort_done: got %b at cycle %0d, expected %b at cycle %0d", o_done, k, e_done, e_cyc - t0);
                    end
                end
            end
            if (k == 6)  i_req[0] = 1'b0;
            if (k == 13) i_req[1] = 1'b0;
        end
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL abort_missing: %0d pulses pending, expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_run();
        int t0, k, e_cyc;
        logic [N-1:0] eg, e_done;
        logic [W-1:0] ec;
        do_reset();
        t0 = cyc;
        i_load_val[15:0] = 16'd8;
        i_req = 4'b0001;
        for (int n = 0; n < 6; n++) begin
            @(negedge i_clk);
            k = cyc - t0;
            n_vec++; if (o_grant !== 4'b0001) begin n_err++; $display("FAIL rst_run_grant: cycle %0d got %b, expected 0001", k, o_grant); end
            n_vec++; if (o_done !== 4'b0000) begin n_err++; $display("FAIL rst_run_done: cycle %0d got %b, expected 0000", k, o_done); end
        end
        n_vec++; if (o_count !== 16'd4) begin n_err++; $display("FAIL rst_run_count: got %h, expected 0004", o_count); end
        i_rst_n = 1'b0;
        i_req = 4'b0100;
        i_load_val[47:32] = 16'd1;
        #1;
        n_vec++; if (o_grant !== 4'b0000) begin n_err++; $display("FAIL rst_async_grant: got %b, expected 0000", o_grant); end
        n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL rst_async_busy: got %b, expected 0", o_busy); end
        n_vec++; if (o_count !== 16'h0000) begin n_err++; $display("FAIL rst_async_count: got %h, expected 0000", o_count); end
        n_vec++; if (o_done !== 4'b0000) begin n_err++; $display("FAIL rst_async_done: got %b, expected 0000", o_done); end
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        t0 = cyc;
        exp_q.push_back(4'b0100); exp_cyc_q.push_back(t0 + 4);
        for (int n = 0; n < 7; n++) begin
            @(negedge i_clk);
            k  = cyc - t0;
            eg = (k >= 1 && k <= 4) ? 4'b0100 : 4'b0000;
            n_vec++; if (o_grant !== eg) begin n_err++; $display("FAIL rst_regrant: cycle %0d got %b, expected %b", k, o_grant, eg); end
            if (k >= 2) begin
                ec = (k == 2) ? 16'd1 : 16'd0;
                n_vec++; if (o_count !== ec) begin n_err++; $display("FAIL rst_regrant_count: cycle %0d got %h, expected %h", k, o_count, ec); end
            end
            if (o_done !== '0 || (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc)) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL rst_done: cycle %0d got %b, expected no pulse", k, o_done);
                end else begin
                    e_done = exp_q.pop_front(); e_cyc = exp_cyc_q.pop_front();
                    if (o_done !== e_done || cyc != e_cyc) begin
                        n_err++; $display("FAIL rst_done: got %b at cycle %0d, expected %b at cycle %0d", o_done, k, e_done, e_cyc - t0);
                    end
                end
            end
            if (k == 4) i_req = 4'b0000;
        end
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rst_missing: %0d pulses pending, expected 0", exp_q.size()); end
    endtask

    task automatic test_max_delay();
        int t0, k, e_cyc;
        logic [N-1:0] e_done;
        logic [W-1:0] ec;
        do_reset();
        t0 = cyc;
        i_load_val[63:48] = 16'hFFFF;
        i_req = 4'b1000;
        exp_q.push_back(4'b1000); exp_cyc_q.push_back(t0 + 65538);
        for (int n = 0; n < 65541; n++) begin
            @(negedge i_clk);
            k = cyc - t0;
            if (k == 1 || k == 65538) begin
                n_vec++; if (o_grant !== 4'b1000) begin n_err++; $display("FAIL max_grant: cycle %0d got %b, expected 1000", k, o_grant); end
            end
            if (k == 65539) begin
                n_vec++; if (o_grant !== 4'b0000) begin n_err++; $display("FAIL max_release: cycle %0d got %b, expected 0000", k, o_grant); end
            end
            if (k == 2 || k == 1002 || k == 65537) begin
                ec = W'(65537 - k);
                n_vec++; if (o_count !== ec) begin n_err++; $display("FAIL max_count: cycle %0d got %h, expected %h", k, o_count, ec); end
            end
            if (o_done !== '0 || (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc)) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL max_done: cycle %0d got %b, expected no pulse", k, o_done);
                end else begin
                    e_done = exp_q.pop_front(); e_cyc = exp_cyc_q.pop_front();
                    if (o_done !== e_done || cyc != e_cyc) begin
                        n_err++; $display("FAIL max_done: got %b at cycle %0d, expected %b at cycle %0d", o_done, k, e_done, e_cyc - t0);
                    end
                end
            end
            if (k == 65538) i_req = 4'b0000;
        end
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL max_missing: %0d pulses pending, expected 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_req();
        test_zero_delay();
        test_abort();
        test_reset_mid_run();
        test_max_delay();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
